// File: rtl/cam_stream_merger.sv
// N-camera pixel stream merger: per-channel FIFOs, round-robin arbiter, registered write port.
// Optional per-channel drop and frame-pixel counters when CAM_STREAM_STATS_EN is defined.
module cam_stream_merger #(
    parameter int unsigned NUM_CAM        = 2,
    parameter int unsigned CAM_DATA_WIDTH = 12,
    parameter int unsigned CAM_LINE       = 9,
    parameter int unsigned CAM_PIXEL      = 10,
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned ADDR_WIDTH     = 17,
    parameter int unsigned TILE_W         = 160,
    parameter int unsigned TILE_H         = 120,
    parameter int unsigned FB_STRIDE      = 320,
    localparam int unsigned CH_W          = (NUM_CAM > 1) ? $clog2(NUM_CAM) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_enable,
    input  logic [NUM_CAM-1:0]            i_ch_en,
    input  logic [NUM_CAM-1:0]            i_we,
    input  logic [NUM_CAM*CAM_DATA_WIDTH-1:0] i_data,
    input  logic [NUM_CAM*CAM_LINE-1:0]   i_line,
    input  logic [NUM_CAM*CAM_PIXEL-1:0]  i_pixel,
    input  logic                          i_ready,
    input  logic                          i_clr_ovf,
    output logic                          o_we,
    output logic [ADDR_WIDTH-1:0]         o_addr_wr,
    output logic [CAM_DATA_WIDTH-1:0]     o_data_wr,
    output logic [CH_W-1:0]               o_ch,
    output logic [NUM_CAM-1:0]            o_ovf
`ifdef CAM_STREAM_STATS_EN
    ,
    output logic [NUM_CAM*16-1:0]         o_drop_cnt,
    output logic [NUM_CAM*20-1:0]         o_frame_pix
`endif
);

    localparam int unsigned IDX_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W  = IDX_W + 1;
    localparam int unsigned WORD_W = ADDR_WIDTH + CAM_DATA_WIDTH;

    logic [WORD_W-1:0] mem [NUM_CAM][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [NUM_CAM];
    logic [PTR_W-1:0]  rd_ptr_q [NUM_CAM];
    logic [31:0]       addr_full [NUM_CAM];
    logic [WORD_W-1:0] push_word [NUM_CAM];
    logic [NUM_CAM-1:0] full, empty, valid_in, push, drop, pop, at_origin;
    logic [CH_W-1:0]   last_grant_q, grant, idx;
    logic [WORD_W-1:0] head_word;
    logic              load, found;

    always_comb begin
        for (int k = 0; k < NUM_CAM; k++) begin
            full[k]  = (wr_ptr_q[k][PTR_W-1] != rd_ptr_q[k][PTR_W-1]) &&
                       (wr_ptr_q[k][IDX_W-1:0] == rd_ptr_q[k][IDX_W-1:0]);
            empty[k] = (wr_ptr_q[k] == rd_ptr_q[k]);
            valid_in[k] = i_enable & i_ch_en[k] & i_we[k] &
                          (32'(i_line[k*CAM_LINE +: CAM_LINE]) < TILE_H) &
                          (32'(i_pixel[k*CAM_PIXEL +: CAM_PIXEL]) < TILE_W);
            // Full is taken before any same-cycle pop.
            push[k] = valid_in[k] & ~full[k];
            drop[k] = valid_in[k] & full[k];
            at_origin[k] = (i_line[k*CAM_LINE +: CAM_LINE] == '0) &&
                           (i_pixel[k*CAM_PIXEL +: CAM_PIXEL] == '0);
            addr_full[k] = 32'(i_line[k*CAM_LINE +: CAM_LINE]) * FB_STRIDE + k * TILE_W +
                           32'(i_pixel[k*CAM_PIXEL +: CAM_PIXEL]);
            push_word[k] = {addr_full[k][ADDR_WIDTH-1:0], i_data[k*CAM_DATA_WIDTH +: CAM_DATA_WIDTH]};
        end
    end

    // Round-robin: search starts one past the last granted channel.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_CAM; i++) begin
            idx = CH_W'((int'(last_grant_q) + i) % NUM_CAM);
            if (!found && !empty[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
        load      = (~o_we | i_ready) & found;
        head_word = mem[grant][rd_ptr_q[grant][IDX_W-1:0]];
        for (int k = 0; k < NUM_CAM; k++) begin
            pop[k] = load && (grant == CH_W'(k));
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CAM; k++) begin
            if (push[k]) begin
                mem[k][wr_ptr_q[k][IDX_W-1:0]] <= push_word[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CAM; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
            end
            last_grant_q <= CH_W'(NUM_CAM - 1);
            o_we         <= 1'b0;
            o_addr_wr    <= '0;
            o_data_wr    <= '0;
            o_ch         <= '0;
            o_ovf        <= '0;
        end else begin
            for (int k = 0; k < NUM_CAM; k++) begin
                if (push[k]) wr_ptr_q[k] <= wr_ptr_q[k] + PTR_W'(1);
                if (pop[k])  rd_ptr_q[k] <= rd_ptr_q[k] + PTR_W'(1);
            end
            // A new overflow wins over a same-cycle clear.
            o_ovf <= (o_ovf & ~{NUM_CAM{i_clr_ovf}}) | drop;
            if (load) begin
                o_we                   <= 1'b1;
                {o_addr_wr, o_data_wr} <= head_word;
                o_ch                   <= grant;
                last_grant_q           <= grant;
            end else if (i_ready) begin
                o_we <= 1'b0;
            end
        end
    end

`ifdef CAM_STREAM_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_drop_cnt  <= '0;
            o_frame_pix <= '0;
        end else begin
            for (int k = 0; k < NUM_CAM; k++) begin
                if (i_clr_ovf) begin
                    o_drop_cnt[k*16 +: 16] <= drop[k] ? 16'd1 : 16'd0;
                end else if (drop[k] && o_drop_cnt[k*16 +: 16] != 16'hFFFF) begin
                    o_drop_cnt[k*16 +: 16] <= o_drop_cnt[k*16 +: 16] + 16'd1;
                end
                if (push[k]) begin
                    o_frame_pix[k*20 +: 20] <= at_origin[k] ? 20'd1 :
                                               o_frame_pix[k*20 +: 20] + 20'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cam_stream_merger.sv
// Self-checking bench for cam_stream_merger: queue-based reference model plus directed
// and randomized stimulus.
module tb_cam_stream_merger;

    localparam int NC = 2, W = 12, LW = 9, PW = 10, DEPTH = 16, AW = 17;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic en, ready, clr;
    logic [NC-1:0] ch_en, we;
    logic [NC*W-1:0] data;
    logic [NC*LW-1:0] line;
    logic [NC*PW-1:0] pixel;
    logic o_we;
    logic [AW-1:0] o_addr_wr;
    logic [W-1:0] o_data_wr;
    logic o_ch;
    logic [NC-1:0] o_ovf;
`ifdef CAM_STREAM_STATS_EN
    logic [NC*16-1:0] o_drop_cnt;
    logic [NC*20-1:0] o_frame_pix;
`endif

    always #5 clk = ~clk;

    cam_stream_merger dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_enable  (en),
        .i_ch_en   (ch_en),
        .i_we      (we),
        .i_data    (data),
        .i_line    (line),
        .i_pixel   (pixel),
        .i_ready   (ready),
        .i_clr_ovf (clr),
        .o_we      (o_we),
        .o_addr_wr (o_addr_wr),
        .o_data_wr (o_data_wr),
        .o_ch      (o_ch),
        .o_ovf     (o_ovf)
`ifdef CAM_STREAM_STATS_EN
        ,
        .o_drop_cnt (o_drop_cnt),
        .o_frame_pix(o_frame_pix)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state
    logic [AW+W-1:0] mq [NC][$];
    logic m_we;
    logic [AW-1:0] m_addr;
    logic [W-1:0] m_data;
    logic m_ch;
    logic [NC-1:0] m_ovf;
    int m_last;
    int m_drop [NC];
    int m_fpix [NC];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NC; k++) begin
            mq[k].delete();
            m_drop[k] = 0;
            m_fpix[k] = 0;
        end
        m_we = 1'b0; m_addr = '0; m_data = '0; m_ch = 1'b0; m_ovf = '0;
        m_last = NC - 1;
    endtask

    task automatic model_edge();
        int sz [NC];
        bit v [NC];
        int lv, pv, c;
        bit found;
        logic [31:0] a;
        logic [AW+W-1:0] wd;
        logic [NC-1:0] dr;
        found = 1'b0;
        c = 0;
        dr = '0;
        for (int k = 0; k < NC; k++) begin
            sz[k] = mq[k].size();
            lv = int'(line[k*LW +: LW]);
            pv = int'(pixel[k*PW +: PW]);
            v[k] = en && ch_en[k] && we[k] && lv < 120 && pv < 160;
        end
        if (!m_we || ready) begin
            for (int i = 1; i <= NC; i++) begin
                if (!found && sz[(m_last + i) % NC] > 0) begin
                    found = 1'b1;
                    c = (m_last + i) % NC;
                end
            end
        end
        if (found) begin
            wd = mq[c].pop_front();
            m_we = 1'b1;
            m_addr = wd[AW+W-1:W];
            m_data = wd[W-1:0];
            m_ch = c[0];
            m_last = c;
        end else if (ready) begin
            m_we = 1'b0;
        end
        for (int k = 0; k < NC; k++) begin
            if (v[k]) begin
                lv = int'(line[k*LW +: LW]);
                pv = int'(pixel[k*PW +: PW]);
                if (sz[k] == DEPTH) begin
                    dr[k] = 1'b1;
                end else begin
                    a = 32'(lv * 320 + k * 160 + pv);
                    mq[k].push_back({a[AW-1:0], data[k*W +: W]});
                    m_fpix[k] = (lv == 0 && pv == 0) ? 1 : (m_fpix[k] + 1) % (1 << 20);
                end
            end
            if (clr) m_drop[k] = dr[k] ? 1 : 0;
            else if (dr[k] && m_drop[k] < 65535) m_drop[k]++;
        end
        m_ovf = (clr ? '0 : m_ovf) | dr;
    endtask

    task automatic compare();
        chk("o_we", 32'(o_we), 32'(m_we));
        if (m_we) begin
            chk("o_addr_wr", 32'(o_addr_wr), 32'(m_addr));
            chk("o_data_wr", 32'(o_data_wr), 32'(m_data));
            chk("o_ch", 32'(o_ch), 32'(m_ch));
        end
        chk("o_ovf", 32'(o_ovf), 32'(m_ovf));
`ifdef CAM_STREAM_STATS_EN
        for (int k = 0; k < NC; k++) begin
            chk("o_drop_cnt", 32'(o_drop_cnt[k*16 +: 16]), 32'(m_drop[k]));
            chk("o_frame_pix", 32'(o_frame_pix[k*20 +: 20]), 32'(m_fpix[k]));
        end
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic idle();
        we = '0;
        clr = 1'b0;
    endtask

    task automatic set_px(input int k, input int l, input int p, input int d);
        logic [31:0] lt, pt, dt;
        lt = 32'(l); pt = 32'(p); dt = 32'(d);
        we[k] = 1'b1;
        line[k*LW +: LW] = lt[LW-1:0];
        pixel[k*PW +: PW] = pt[PW-1:0];
        data[k*W +: W] = dt[W-1:0];
    endtask

    initial begin
        int cnt;
        en = 1'b1; ch_en = 2'b11; we = '0; data = '0; line = '0; pixel = '0;
        ready = 1'b1; clr = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        chk("rst_we", 32'(o_we), 0);
        chk("rst_addr", 32'(o_addr_wr), 0);
        chk("rst_data", 32'(o_data_wr), 0);
        chk("rst_ch", 32'(o_ch), 0);
        chk("rst_ovf", 32'(o_ovf), 0);
        @(negedge clk) rst_n = 1'b1;

        // Single pixel on ch0
        set_px(0, 2, 5, 'hABC);
        step();
        idle();
        step();
        chk("single_we", 32'(o_we), 1);
        chk("single_addr", 32'(o_addr_wr), 645);
        chk("single_data", 32'(o_data_wr), 'hABC);
        chk("single_ch", 32'(o_ch), 0);
        step();

        // ch1 tile offset, then an out-of-tile pixel
        set_px(1, 0, 7, 'h123);
        step();
        idle();
        step();
        chk("tile_addr", 32'(o_addr_wr), 167);
        chk("tile_ch", 32'(o_ch), 1);
        set_px(1, 0, 160, 'h55);
        step();
        idle();
        repeat (3) step();
        chk("oot_we", 32'(o_we), 0);
        chk("oot_ovf", 32'(o_ovf), 0);

        // Fairness: both channels fed every cycle
        for (int i = 0; i < 20; i++) begin
            set_px(0, $urandom_range(0, 119), $urandom_range(0, 159), $urandom_range(0, 4095));
            set_px(1, $urandom_range(0, 119), $urandom_range(0, 159), $urandom_range(0, 4095));
            step();
            if (i >= 1) begin
                chk("fair_we", 32'(o_we), 1);
                chk("fair_ch", 32'(o_ch), (i - 1) % 2);
            end
        end
        idle();
        repeat (25) step();

        // Backpressure: 20 pushes into ch0 with i_ready low
        ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            set_px(0, 1, i, i + 1);
            step();
            if (i >= 1) begin
                chk("bp_we", 32'(o_we), 1);
                chk("bp_addr", 32'(o_addr_wr), 320);
                chk("bp_data", 32'(o_data_wr), 1);
            end
        end
        chk("bp_ovf", 32'(o_ovf), 1);
`ifdef CAM_STREAM_STATS_EN
        chk("bp_drop_cnt", 32'(o_drop_cnt[15:0]), 3);
`endif
        idle();
        ready = 1'b1;
        cnt = 1;
        repeat (25) begin
            step();
            if (o_we) cnt++;
        end
        chk("bp_words", 32'(cnt), 17);

        // Overflow clear: quiet clear, then clear colliding with a new drop, then quiet clear
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_quiet0", 32'(o_ovf), 0);
        ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            set_px(0, 3, i, i);
            step();
        end
        set_px(0, 3, 17, 'h77);
        clr = 1'b1;
        step();
        chk("clr_collide", 32'(o_ovf[0]), 1);
        we = '0;
        step();
        chk("clr_quiet1", 32'(o_ovf[0]), 0);
        idle();
        ready = 1'b1;
        repeat (20) step();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 9) != 0);
            ch_en = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b11;
            we = 2'($urandom);
            for (int k = 0; k < NC; k++) begin
                if ($urandom_range(0, 30) == 0) set_px(k, 0, 0, $urandom_range(0, 4095));
                else set_px(k, $urandom_range(0, 130), $urandom_range(0, 170),
                            $urandom_range(0, 4095));
                we[k] = $urandom_range(0, 1) == 1;
            end
            ready = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 19) == 0);
            step();
        end
        en = 1'b1; ch_en = 2'b11;
        idle();
        ready = 1'b1;
        repeat (40) step();

        // Reset mid-stream
        ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_px(0, 5, i, i);
            set_px(1, 6, i, i + 100);
            step();
        end
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_we", 32'(o_we), 0);
        chk("mid_rst_ovf", 32'(o_ovf), 0);
        model_reset();
        idle();
        @(negedge clk) rst_n = 1'b1;
        ready = 1'b1;
        set_px(0, 4, 9, 'h111);
        set_px(1, 4, 9, 'h222);
        step();
        idle();
        step();
        chk("post_rst_we", 32'(o_we), 1);
        chk("post_rst_ch", 32'(o_ch), 0);
        chk("post_rst_data", 32'(o_data_wr), 'h111);
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cam_stream_merger.md
Name: cam_stream_merger

Overview:
N-camera pixel stream merger feeding the single-port frame-buffer write interface. It generalises the fixed two-camera output path to NUM_CAM channels. Each channel has its own FIFO with overflow flagging. A round-robin arbiter selects between channels, and the write port has valid/ready backpressure. The block sits after the per-camera rgb2gray/imag_transform stages and replaces the fixed two-camera save stage; each camera is tiled side by side in the frame buffer.

Parameters:
NUM_CAM, 2, number of camera channels (1..8)
CAM_DATA_WIDTH, 12, pixel data width
CAM_LINE, 9, line coordinate width
CAM_PIXEL, 10, pixel coordinate width
FIFO_DEPTH, 16, words per channel FIFO, power of 2, >=2
ADDR_WIDTH, 17, frame-buffer address width
TILE_W, 160, tile width in pixels per camera
TILE_H, 120, tile height in lines
FB_STRIDE, 320, frame-buffer line stride in words

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_enable  in  1  global accept enable
i_ch_en  in  NUM_CAM  per-channel accept enable
i_we  in  NUM_CAM  per-channel pixel strobe
i_data  in  NUM_CAM*CAM_DATA_WIDTH  packed pixel data; channel k at [k*W +: W]
i_line  in  NUM_CAM*CAM_LINE  packed line coordinates
i_pixel  in  NUM_CAM*CAM_PIXEL  packed pixel coordinates
i_ready  in  1  frame buffer accepts write this cycle
i_clr_ovf  in  1  clears all overflow flags
o_we  out  1  write valid
o_addr_wr  out  ADDR_WIDTH  write address
o_data_wr  out  CAM_DATA_WIDTH  write data
o_ch  out  $clog2(NUM_CAM) (min 1)  source channel of the current word
o_ovf  out  NUM_CAM  sticky per-channel overflow flags

Behaviour:
- Reset (async, rst_n=0): all FIFOs are emptied. o_we=0, o_addr_wr=0, o_data_wr=0, o_ch=0, o_ovf=0. The round-robin pointer is set so that channel 0 has first priority.
- Push, channel k: push happens when i_enable & i_ch_en[k] & i_we[k] & in-tile & !full[k]. In-tile means line<TILE_H and pixel<TILE_W.
- An out-of-tile pixel is silently discarded and does not set overflow.
- Full-drop: a valid, in-tile pixel that arrives while full[k] is dropped and sets o_ovf[k] on the next edge.
- Full is evaluated before any same-cycle pop, so a push to a full FIFO is dropped even if that FIFO pops in the same cycle.
- Stored FIFO word: {addr, data}. addr = line*FB_STRIDE + k*TILE_W + pixel, computed at push time in full precision and truncated to ADDR_WIDTH.
- Output stage: single register. It loads when (!o_we | i_ready) and at least one FIFO is non-empty. Otherwise, if i_ready is high, o_we clears.
- Stability: while o_we=1 and i_ready=0, o_we, o_addr_wr, o_data_wr and o_ch hold stable.
- Arbiter: round-robin. The search starts at last_grant+1 mod NUM_CAM. The first non-empty channel is granted and popped in the same cycle the output register loads. last_grant updates only on a grant.
- Latency: a pixel pushed into an empty FIFO at edge N, with the output register free, appears with o_we=1 after edge N+1.
- Throughput: 1 word/cycle sustained while i_ready=1.
- i_enable or i_ch_en[k] deasserted: new input for the affected channels is ignored. Queued words still drain. These inputs never flush a FIFO.
- o_ovf clear: i_clr_ovf clears o_ovf. A same-cycle new overflow wins, so the flag stays set.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally. Full is the MSB differing with the remaining bits equal.

Optional Feature:
Macro CAM_STREAM_STATS_EN.
- Defined: adds output o_drop_cnt, width NUM_CAM*16. It holds per-channel saturating counters (at 16'hFFFF) of full-drops.
- Also adds output o_frame_pix, width NUM_CAM*20. It holds per-channel counts of pixels accepted since the last pixel with line==0 and pixel==0. Such a pixel restarts its channel's count at 1.
- Both are reset to 0. i_clr_ovf also zeroes o_drop_cnt.
- Undefined: neither port exists and no counter logic is built. Core behaviour is identical in both cases.

Test Plan:
- Single pixel, ch0: line=2, pixel=5, data=12'hABC, i_ready=1. Expect o_we=1 one cycle later, o_addr_wr=645, o_data_wr=12'hABC, o_ch=0.
- ch1 tile offset: line=0, pixel=7. Expect o_addr_wr=167. A second pixel with pixel=160 on ch1 never appears and o_ovf stays 0.
- Fairness: both channels are fed continuously with i_ready=1. Expect o_ch to alternate 0,1,0,1 and 1 word/cycle output.
- Backpressure: hold i_ready=0 for 20 cycles while ch0 pushes 20 pixels. Expect o_we and o_addr_wr stable throughout. After FIFO_DEPTH+1 words are held (16 in the FIFO, 1 in the output register), the remaining 3 are dropped. Expect o_ovf[0]=1 and, with CAM_STREAM_STATS_EN, drop count=3. After releasing i_ready, exactly 17 words are output in push order.
- Overflow clear: assert i_clr_ovf in the same cycle as a new drop, then again in a quiet cycle. Expect o_ovf[0]=1 after the first assertion and 0 after the second.
- Reset mid-stream: deassert rst_n while o_we=1 and FIFOs are half full. Expect o_we=0 immediately with no clock. After release, no stale words are output and the first grant goes to ch0.
